// File: rtl/wave_voice_gen_pkg.sv
// Shared constants for the wave voice generator: waveform select codes,
// select width and the amplitude scaling shift.
package wave_voice_gen_pkg;

    localparam int SEL_W       = 3;
    localparam int LEVEL_SHIFT = 8;

    typedef enum logic [SEL_W-1:0] {
        WAVE_SINE     = 3'd0,
        WAVE_SQUARE   = 3'd1,
        WAVE_SAW      = 3'd2,
        WAVE_TRIANGLE = 3'd3,
        WAVE_PULSE    = 3'd4
    } wave_sel_e;

endpackage

// File: rtl/wave_voice_gen_quarter_sine_rom.sv
// Quarter-wave sine magnitude table with a registered (1-cycle) read.
// Only compiled when WAVE_VOICE_GEN_SINE_EN is defined.
`ifdef WAVE_VOICE_GEN_SINE_EN
module quarter_sine_rom #(
    parameter int PHASE_W  = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [PHASE_W-3:0]  i_addr,
    output logic [SAMPLE_W-1:0] o_data
);

    localparam int DEPTH = 1 << (PHASE_W - 2);

    typedef logic [SAMPLE_W-1:0] table_t [DEPTH];

    // Table is built at elaboration; the sine is a Taylor series so only
    // basic real arithmetic is needed. Entries sample mid-step (k + 0.5).
    function automatic table_t build_table();
        table_t t;
        real    maxp;
        real    x;
        real    term;
        real    s;
        maxp = (2.0 ** (SAMPLE_W - 1)) - 1.0;
        for (int k = 0; k < DEPTH; k++) begin
            x    = 3.14159265358979323846 * (real'(k) + 0.5) / (2.0 * real'(DEPTH));
            s    = x;
            term = x;
            for (int n = 1; n < 10; n++) begin
                term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
                s    = s + term;
            end
            t[k] = SAMPLE_W'($rtoi(maxp * s + 0.5));
        end
        return t;
    endfunction

    localparam table_t ROM = build_table();

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_data <= ROM[i_addr];
        end
    end

endmodule
`endif

// File: rtl/wave_voice_gen.sv
// Three-stage voice oscillator: decode/register, raw waveform, level scaling.
// Define WAVE_VOICE_GEN_SINE_EN to build the sine ROM; otherwise select 0 is triangle.
module wave_voice_gen
    import wave_voice_gen_pkg::*;
#(
    parameter int PHASE_W  = 10,
    parameter int SAMPLE_W = 16,
    parameter int VOICE_W  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic                       i_hold,
    input  logic [PHASE_W-1:0]         i_phase,
    input  logic [SEL_W-1:0]           i_wave_select,
    input  logic [PHASE_W-1:0]         i_duty,
    input  logic [7:0]                 i_level,
    input  logic [VOICE_W-1:0]         i_voice_index,
    output logic                       o_valid,
    output logic [VOICE_W-1:0]         o_voice_index,
    output logic signed [SAMPLE_W-1:0] o_sample,
    output logic                       o_err
);

    // Handshake: i_valid marks a request in any cycle with i_hold=0; there is
    // no backpressure to the source. i_hold=1 freezes every stage and ignores
    // inputs, so a held o_valid=1 is the same result re-presented.

    localparam int MSB    = PHASE_W - 1;
    localparam int TRI_SH = SAMPLE_W - PHASE_W + 1;
    localparam logic [SAMPLE_W-1:0] MAXP_V = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] MINN_V = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                 s1_valid;
    logic [VOICE_W-1:0]   s1_idx;
    logic [PHASE_W-1:0]   s1_phase;
    logic [SEL_W-1:0]     s1_sel;
    logic [PHASE_W-1:0]   s1_duty;
    logic [7:0]           s1_level;

    logic                        s2_valid;
    logic [VOICE_W-1:0]          s2_idx;
    logic signed [SAMPLE_W-1:0]  s2_raw;
    logic                        s2_err;
    logic [7:0]                  s2_level;

    logic [SAMPLE_W-1:0]  raw;
    logic                 illegal;
    logic [PHASE_W-2:0]   tri_t;
    logic [SAMPLE_W-1:0]  tri_raw;
    logic signed [SAMPLE_W+8:0] prod;

`ifdef WAVE_VOICE_GEN_SINE_EN
    // The ROM's read register is part of stage 1: its address is derived
    // from the incoming phase so the magnitude lines up with s1_phase.
    logic [PHASE_W-3:0]  rom_addr;
    logic [SAMPLE_W-1:0] rom_mag;

    assign rom_addr = i_phase[PHASE_W-3:0] ^ {(PHASE_W-2){i_phase[PHASE_W-2]}};

    quarter_sine_rom #(
        .PHASE_W  (PHASE_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .i_clk  (i_clk),
        .i_en   (~i_hold),
        .i_addr (rom_addr),
        .o_data (rom_mag)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_phase <= '0;
            s1_sel   <= '0;
            s1_duty  <= '0;
            s1_level <= '0;
        end else if (!i_hold) begin
            s1_valid <= i_valid;
            s1_idx   <= i_voice_index;
            s1_phase <= i_phase;
            s1_sel   <= i_wave_select;
            s1_duty  <= i_duty;
            s1_level <= i_level;
        end
    end

    assign tri_t   = s1_phase[MSB-1:0] ^ {(PHASE_W-1){s1_phase[MSB]}};
    assign tri_raw = {tri_t, {TRI_SH{1'b0}}} + MINN_V;

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (s1_sel)
`ifdef WAVE_VOICE_GEN_SINE_EN
            WAVE_SINE:     raw = s1_phase[MSB] ? -rom_mag : rom_mag;
`else
            WAVE_SINE:     raw = tri_raw;
`endif
            WAVE_SQUARE:   raw = s1_phase[MSB] ? MINN_V : MAXP_V;
            WAVE_SAW:      raw = {~s1_phase[MSB], s1_phase[MSB-1:0], {(SAMPLE_W-PHASE_W){1'b0}}};
            WAVE_TRIANGLE: raw = tri_raw;
            WAVE_PULSE:    raw = (s1_phase < s1_duty) ? MAXP_V : MINN_V;
            default:       illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_raw   <= '0;
            s2_err   <= 1'b0;
            s2_level <= '0;
        end else if (!i_hold) begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_raw   <= raw;
            s2_err   <= s1_valid & illegal;
            s2_level <= s1_level;
        end
    end

    // Full-precision signed product; level is zero-extended so it stays positive.
    assign prod = $signed({{9{s2_raw[SAMPLE_W-1]}}, s2_raw})
                * $signed({{(SAMPLE_W+1){1'b0}}, s2_level});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_voice_index <= '0;
            o_sample      <= '0;
            o_err         <= 1'b0;
        end else if (!i_hold) begin
            o_valid       <= s2_valid;
            o_voice_index <= s2_idx;
            o_sample      <= SAMPLE_W'(prod >>> LEVEL_SHIFT);
            o_err         <= s2_err;
        end
    end

endmodule

// File: tb/tb_wave_voice_gen.sv
// Directed bench for wave_voice_gen at default parameters; expected samples
// are hand-computed constants queued per request and matched in order.
module tb_wave_voice_gen;
    import wave_voice_gen_pkg::*;

    logic               i_clk;
    logic               i_reset;
    logic               i_valid;
    logic               i_hold;
    logic [9:0]         i_phase;
    logic [2:0]         i_wave_select;
    logic [9:0]         i_duty;
    logic [7:0]         i_level;
    logic [7:0]         i_voice_index;
    logic               o_valid;
    logic [7:0]         o_voice_index;
    logic signed [15:0] o_sample;
    logic               o_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [24:0] exp_q[$];
    logic hold_prev = 1'b0;
    logic rst_prev  = 1'b1;

    wave_voice_gen dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_hold        (i_hold),
        .i_phase       (i_phase),
        .i_wave_select (i_wave_select),
        .i_duty        (i_duty),
        .i_level       (i_level),
        .i_voice_index (i_voice_index),
        .o_valid       (o_valid),
        .o_voice_index (o_voice_index),
        .o_sample      (o_sample),
        .o_err         (o_err)
    );

    // Clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [2:0] sel, input logic [9:0] ph, input logic [9:0] duty,
                         input logic [7:0] lvl, input logic [7:0] idx);
        i_valid       = 1'b1;
        i_wave_select = sel;
        i_phase       = ph;
        i_duty        = duty;
        i_level       = lvl;
        i_voice_index = idx;
        @(negedge i_clk);
    endtask

    task automatic req(input logic [2:0] sel, input logic [9:0] ph, input logic [9:0] duty,
                       input logic [7:0] lvl, input logic [7:0] idx,
                       input logic signed [15:0] es, input logic ee);
        exp_q.push_back({idx, ee, es});
        drive(sel, ph, duty, lvl, idx);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge i_clk);
        check("drain_empty", exp_q.size(), 0);
        @(negedge i_clk);
    endtask

    // Scoreboard: a result is new only if the edge that produced it was not held
    always @(posedge i_clk) begin
        hold_prev = i_hold;
        rst_prev  = i_reset;
    end

    always @(negedge i_clk) begin
        logic [24:0] e;
        if (o_valid && !hold_prev && !rst_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("voice_index", o_voice_index, e[24:17]);
                check("err", o_err, e[16]);
                check("sample", {o_sample}, e[15:0]);
            end
        end
    end

    logic        snap_v;
    logic [15:0] snap_s;
    logic [7:0]  snap_i;
    logic        snap_e;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_hold = 1'b0;
        i_phase = '0;
        i_wave_select = '0;
        i_duty = '0;
        i_level = '0;
        i_voice_index = '0;
        repeat (3) @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_err", o_err, 0);
        check("rst_sample", {o_sample}, 0);
        check("rst_index", o_voice_index, 0);
        i_reset = 1'b0;

        // Square, level 255, with exact 3-cycle latency
        req(3'd1, 10'd0, 10'd0, 8'd255, 8'd1, 16'sd32639, 1'b0);
        check("lat_c1", o_valid, 0);
        req(3'd1, 10'd512, 10'd0, 8'd255, 8'd2, -16'sd32640, 1'b0);
        check("lat_c2", o_valid, 0);
        idle(1);
        check("lat_c3", o_valid, 1);
        drain();

        // Saw, level 128, back-to-back tags 5 then 6
        req(3'd2, 10'd0, 10'd0, 8'd128, 8'd5, -16'sd16384, 1'b0);
        req(3'd2, 10'd1023, 10'd0, 8'd128, 8'd6, 16'sd16352, 1'b0);
        idle(2);
        check("b2b_second_valid", o_valid, 1);
        drain();

        // Select 0: sine when built, triangle otherwise
`ifdef WAVE_VOICE_GEN_SINE_EN
        req(3'd0, 10'd0, 10'd0, 8'd255, 8'd7, 16'sd100, 1'b0);
        req(3'd0, 10'd768, 10'd0, 8'd255, 8'd8, -16'sd32640, 1'b0);
`else
        req(3'd0, 10'd0, 10'd0, 8'd255, 8'd7, -16'sd32640, 1'b0);
        req(3'd0, 10'd768, 10'd0, 8'd255, 8'd8, -16'sd128, 1'b0);
`endif
        // Triangle, saw mid-point, levels 0 and 1
        req(3'd3, 10'd256, 10'd0, 8'd255, 8'd20, 16'sd0, 1'b0);
        req(3'd3, 10'd512, 10'd0, 8'd255, 8'd21, 16'sd32512, 1'b0);
        req(3'd3, 10'd1023, 10'd0, 8'd255, 8'd22, -16'sd32640, 1'b0);
        req(3'd2, 10'd511, 10'd0, 8'd255, 8'd23, -16'sd64, 1'b0);
        req(3'd1, 10'd0, 10'd0, 8'd0, 8'd24, 16'sd0, 1'b0);
        req(3'd1, 10'd0, 10'd0, 8'd1, 8'd25, 16'sd127, 1'b0);
        req(3'd1, 10'd512, 10'd0, 8'd1, 8'd26, -16'sd128, 1'b0);
        // Pulse: duty 0 is always low; duty 512 splits at the midpoint
        req(3'd4, 10'd0, 10'd0, 8'd255, 8'd30, -16'sd32640, 1'b0);
        req(3'd4, 10'd1023, 10'd0, 8'd255, 8'd31, -16'sd32640, 1'b0);
        req(3'd4, 10'd300, 10'd0, 8'd255, 8'd32, -16'sd32640, 1'b0);
        req(3'd4, 10'd100, 10'd512, 8'd255, 8'd33, 16'sd32639, 1'b0);
        req(3'd4, 10'd512, 10'd512, 8'd255, 8'd34, -16'sd32640, 1'b0);
        // Illegal selects, then a legal one clears o_err
        req(3'd6, 10'd100, 10'd0, 8'd255, 8'd40, 16'sd0, 1'b1);
        req(3'd5, 10'd0, 10'd0, 8'd255, 8'd41, 16'sd0, 1'b1);
        req(3'd7, 10'd512, 10'd0, 8'd255, 8'd42, 16'sd0, 1'b1);
        req(3'd1, 10'd0, 10'd0, 8'd255, 8'd43, 16'sd32639, 1'b0);
        drain();

        // Hold for 4 cycles with a result presented and two more in flight
        req(3'd1, 10'd0, 10'd0, 8'd255, 8'd10, 16'sd32639, 1'b0);
        req(3'd2, 10'd0, 10'd0, 8'd128, 8'd11, -16'sd16384, 1'b0);
        req(3'd3, 10'd256, 10'd0, 8'd255, 8'd12, 16'sd0, 1'b0);
        i_hold = 1'b1;
        i_valid = 1'b1;
        i_wave_select = 3'd1;
        i_phase = 10'd3;
        i_level = 8'd77;
        i_voice_index = 8'd99;
        snap_v = o_valid;
        snap_s = o_sample;
        snap_i = o_voice_index;
        snap_e = o_err;
        check("hold_snap_valid", snap_v, 1);
        repeat (4) begin
            @(negedge i_clk);
            check("hold_valid", o_valid, snap_v);
            check("hold_sample", {o_sample}, snap_s);
            check("hold_index", o_voice_index, snap_i);
            check("hold_err", o_err, snap_e);
        end
        i_hold = 1'b0;
        req(3'd1, 10'd512, 10'd0, 8'd255, 8'd13, -16'sd32640, 1'b0);
        req(3'd4, 10'd100, 10'd512, 8'd255, 8'd14, 16'sd32639, 1'b0);
        drain();

        // Reset with three requests in flight; new request on reset release
        drive(3'd1, 10'd0, 10'd0, 8'd255, 8'd50);
        drive(3'd2, 10'd0, 10'd0, 8'd255, 8'd51);
        i_reset = 1'b1;
        drive(3'd3, 10'd0, 10'd0, 8'd255, 8'd52);
        check("rst_flight_c1", o_valid, 0);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("rst_flight_c2", o_valid, 0);
        i_reset = 1'b0;
        req(3'd2, 10'd1023, 10'd0, 8'd128, 8'd60, 16'sd16352, 1'b0);
        check("rst_release_c1", o_valid, 0);
        idle(1);
        check("rst_release_c2", o_valid, 0);
        idle(1);
        check("rst_release_c3", o_valid, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_voice_gen.md
WAVE_VOICE_GEN -- requirements
Module: wave_voice_gen

Interface
REQ-001 Parameter PHASE_W, default 10: oscillator phase width; SHALL be 4..16.
REQ-002 Parameter SAMPLE_W, default 16: signed output sample width; SHALL exceed PHASE_W.
REQ-003 Parameter VOICE_W, default 8: voice index width.
REQ-004 Port i_clk, input, 1: single clock; all state on rising edge.
REQ-005 Port i_reset, input, 1: synchronous, active-high reset.
REQ-006 Port i_valid, input, 1: request strobe, one voice per cycle.
REQ-007 Port i_hold, input, 1: pipeline stall; every stage register keeps its value.
REQ-008 Port i_phase, input, PHASE_W: unsigned voice phase.
REQ-009 Port i_wave_select, input, 3: waveform code: 0 sine, 1 square, 2 saw, 3 triangle, 4 pulse; 5..7 illegal.
REQ-010 Port i_duty, input, PHASE_W: pulse threshold.
REQ-011 Port i_level, input, 8: unsigned amplitude.
REQ-012 Port i_voice_index, input, VOICE_W: tag carried with the request.
REQ-013 Port o_valid, output, 1: result strobe.
REQ-014 Port o_voice_index, output, VOICE_W: tag of the result.
REQ-015 Port o_sample, output, SAMPLE_W signed: scaled sample.
REQ-016 Port o_err, output, 1: pulses with o_valid when the request's select was illegal.

Function
REQ-017 Three-stage pipeline SHALL be used. S1 registers the inputs and the sine ROM address. S2 registers the raw sample. S3 registers the scaled output. Latency is exactly 3 unstalled cycles.
REQ-018 While i_hold=1, inputs SHALL be ignored and all outputs SHALL hold their values. A held o_valid=1 SHALL be re-presented and SHALL NOT be counted as a new result.
REQ-019 Notation: MAXP = 2^(SAMPLE_W-1)-1 and MINN = -2^(SAMPLE_W-1).
REQ-020 Square: raw = MAXP when phase MSB is 0, else MINN.
REQ-021 Pulse: raw = MAXP when phase < i_duty (unsigned compare), else MINN. i_duty=0 SHALL give MINN for every phase.
REQ-022 Saw: raw = {~phase[MSB], phase[MSB-1:0]} left-aligned into SAMPLE_W with zero fill.
REQ-023 Triangle: t = phase[MSB-1:0], inverted when phase MSB is 1. raw = (t << (SAMPLE_W-PHASE_W+1)) + MINN.
REQ-024 Sine: index = phase[MSB-2:0], inverted when phase[MSB-1] is 1. mag = ROM[index]. raw = mag when phase MSB is 0, else -mag.
REQ-025 ROM contents: ROM[k] = round(MAXP*sin(pi/2*(k+0.5)/2^(PHASE_W-2))), for 2^(PHASE_W-2) entries.
REQ-026 Illegal select: raw = 0 and o_err=1 for that result.
REQ-027 Scaling: o_sample = (raw * i_level) >>> 8, arithmetic shift, full-precision signed product. i_level=0 gives 0.
REQ-028 Phase wrap from maximum to 0 needs no special handling. Results SHALL be a pure function of the request fields.

Reset
REQ-029 On i_reset=1, all valid bits, o_valid, o_err, o_sample and o_voice_index SHALL clear to 0 at the next edge.
REQ-030 Reset SHALL override i_hold. Requests in flight SHALL be discarded and never emerge.
REQ-031 i_valid asserted in the cycle reset deasserts SHALL be accepted normally.

Configuration
REQ-032 Macro WAVE_VOICE_GEN_SINE_EN. When defined, the sine ROM and the sine path SHALL be built.
REQ-033 When the macro is undefined, no ROM SHALL be built and select 0 SHALL produce the triangle output, with o_err=0.

Structure
REQ-034 A shared package SHALL hold the waveform select codes, the 3-bit select width and the level shift constant 8.
REQ-035 Sub-module quarter_sine_rom SHALL hold the ROM: parameters PHASE_W and SAMPLE_W, synchronous read, 1-cycle latency, used only under the macro.

Verification
REQ-036 Defaults, square, level 255: phase 0 -> o_sample 32639 three cycles after the request; phase 512 -> -32640.
REQ-037 Saw, level 128: phase 0 -> -16384; phase 1023 -> 16352. Back-to-back tags 5 then 6 SHALL emerge in the same order on consecutive cycles.
REQ-038 Sine (macro on), level 255: phase 0 -> (101*255)>>>8 = 100; phase 768 -> -32640. With the macro off, phase 0 -> triangle value -32640.
REQ-039 Pulse with i_duty 0 -> MINN-scaled result for every phase; select 6 -> o_sample 0 with o_err=1.
REQ-040 Hold i_hold high for 4 cycles mid-stream -> outputs frozen, then resume with no loss or duplication. Reset asserted while 3 requests are in flight -> o_valid stays 0 until a new request completes.
